mul_reg: RTL and testbench

- Registered signed 8x8 multiplier built on radix-4 Booth encoding. It is the multiply stage of the MACC datapath in the CNN ALU.
- Each clock it accepts two signed 8-bit operands and presents their product, truncated to 15 bits, from an output register one cycle later.
- The design is purely datapath: no handshake and no enable.

---
 rtl/mul_reg.sv | 51 +++++
 tb/tb_mul_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mul_reg.sv
// Registered signed 8x8 multiplier, radix-4 Booth encoded on y.
// Product is truncated to 15 bits and wraps modulo 2^15.
module mul_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [14:0] o_mul
);

  logic [8:0]  yb;
  logic [15:0] xs;
  logic [2:0]  grp [4];
  logic [15:0] pp  [4];
  logic [14:0] sum;

  assign yb = {y, 1'b0};
  assign xs = {{8{x[7]}}, x};

  for (genvar g = 0; g < 4; g++) begin : g_grp
    assign grp[g] = yb[2*g+2 -: 3];
  end

  // Select/shift/negate of x per Booth digit, then weight by 4^i
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = '0;
      unique case (1'b1)
        (grp[i] == 3'b001) || (grp[i] == 3'b010):
          pp[i] = xs;
        (grp[i] == 3'b011):
          pp[i] = xs << 1;
        (grp[i] == 3'b100):
          pp[i] = -(xs << 1);
        (grp[i] == 3'b101) || (grp[i] == 3'b110):
          pp[i] = -xs;
        default:
          pp[i] = '0;
      endcase
      pp[i] = pp[i] << (2 * i);
    end
  end

  assign sum = 15'(pp[0] + pp[1] + pp[2] + pp[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_mul <= '0;
    else        o_mul <= sum;
  end

endmodule

// File: tb/tb_mul_reg.sv
// Bench for mul_reg: directed products, overflow wrap, and
// randomized back-to-back operands with a mid-stream reset.
module tb_mul_reg;

  logic        clk;
  logic        rst_n;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [14:0] o_mul;

  int n_cmp;
  int n_bad;

  mul_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .o_mul (o_mul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ref_mul(input logic [7:0] a,
                                          input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p[14:0];
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    x = 8'd7;
    y = 8'd9;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (o_mul !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_hold got=%h want=%h", o_mul, 15'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_mul !== 15'd63) begin
      n_bad++;
      $display("FAIL reset_first_load got=%h want=%h", o_mul, 15'd63);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_mul !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_async got=%h want=%h", o_mul, 15'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_positive;
    logic [7:0]  tx [11];
    logic [7:0]  ty [11];
    logic [14:0] te [11];
    tx = '{8'd1, 8'd2, 8'd8, 8'd15, 8'd56, 8'd127, 8'd4, 8'd11,
           8'd0, 8'd1, 8'd0};
    ty = '{8'd1, 8'd2, 8'd3, 8'd15, 8'd25, 8'd127, 8'd3, 8'd6,
           8'd0, 8'd0, 8'd1};
    te = '{15'd1, 15'd4, 15'd24, 15'd225, 15'd1400, 15'd16129,
           15'd12, 15'd66, 15'd0, 15'd0, 15'd0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      x = tx[i];
      y = ty[i];
      @(posedge clk);
      #1;
      n_cmp++;
      if (o_mul !== te[i]) begin
        n_bad++;
        $display("FAIL positive[%0d] %0d*%0d got=%h want=%h",
                 i, tx[i], ty[i], o_mul, te[i]);
      end
    end
  endtask

  task automatic test_negative;
    logic [7:0]  tx [5];
    logic [7:0]  ty [5];
    logic [14:0] te [5];
    tx = '{8'hFF, 8'h01, 8'hFF, 8'h80, 8'hAA};
    ty = '{8'h01, 8'hFF, 8'hFF, 8'h01, 8'h55};
    te = '{15'h7FFF, 15'h7FFF, 15'h0001, 15'h7F80, 15'h6372};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      x = tx[i];
      y = ty[i];
      @(posedge clk);
      #1;
      n_cmp++;
      if (o_mul !== te[i]) begin
        n_bad++;
        $display("FAIL negative[%0d] x=%h y=%h got=%h want=%h",
                 i, tx[i], ty[i], o_mul, te[i]);
      end
    end
  endtask

  task automatic test_overflow;
    @(negedge clk);
    x = 8'h80;
    y = 8'h80;
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_mul !== 15'h4000) begin
      n_bad++;
      $display("FAIL overflow_wrap got=%h want=%h", o_mul, 15'h4000);
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] exp;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 100) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_mul !== 15'd0) begin
          n_bad++;
          $display("FAIL b2b_reset_async got=%h want=%h", o_mul, 15'd0);
        end
      end
      if (i == 103) begin
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (o_mul !== 15'd0) begin
          n_bad++;
          $display("FAIL b2b_reset_release got=%h want=%h", o_mul, 15'd0);
        end
      end
      x = 8'($urandom);
      y = 8'($urandom);
      if (i % 37 == 5) begin
        x = 8'h80;
        y = 8'($urandom_range(0, 1) != 0 ? 8'h80 : 8'h7F);
      end
      exp = rst_n ? ref_mul(x, y) : 15'd0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (o_mul !== exp) begin
        n_bad++;
        $display("FAIL b2b[%0d] x=%h y=%h got=%h want=%h",
                 i, x, y, o_mul, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    x = '0;
    y = '0;
    test_reset;
    test_positive;
    test_negative;
    test_overflow;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
